// File: rtl/meter_pkg.sv
// Shared types and arithmetic for the peak meter: magnitude width, hold FSM
// states and the release step used by both the level and the hold marker.
package meter_pkg;

  localparam int MAG_W = 23;

  typedef enum logic {HOLD, FALL} hold_state_t;

  // One release step: subtract value>>shift (at least 1 LSB), never going below floor_v.
  function automatic logic [MAG_W-1:0] decay(input logic [MAG_W-1:0] value,
                                             input logic [MAG_W-1:0] floor_v,
                                             input int unsigned       shift);
    logic [MAG_W-1:0] dec;
    logic [MAG_W-1:0] rem;
    dec = value >> shift;
    if (dec == '0) dec = MAG_W'(1);
    rem = (dec > value) ? '0 : value - dec;
    return (rem > floor_v) ? rem : floor_v;
  endfunction

endpackage

// File: rtl/meter_pwm.sv
// Free-running PWM for the bargraph tube current. The duty value is only
// reloaded on the last count of a period, so a period never mixes two duties.
module meter_pwm #(
  parameter int PWM_BITS = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PWM_BITS-1:0] duty_in,
  output logic                pwm_out
);

  logic [PWM_BITS-1:0] cnt_q, cnt_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic                pwm_q, pwm_d;

  always_comb begin
    cnt_d  = cnt_q + PWM_BITS'(1);
    duty_d = duty_q;
    if (&cnt_q) duty_d = duty_in;
    pwm_d  = (cnt_q < duty_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      duty_q <= '0;
      pwm_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      duty_q <= duty_d;
      pwm_q  <= pwm_d;
    end
  end

  assign pwm_out = pwm_q;

endmodule

// File: rtl/peak_meter_driver.sv
// Meter ballistics on incoming window peaks: instant attack, exponential release,
// and a peak-hold marker that freezes for a number of updates before falling.
module peak_meter_driver
  import meter_pkg::*;
#(
  parameter int DECAY_SHIFT  = 4,
  parameter int HOLD_UPDATES = 48,
  parameter int PWM_BITS     = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vin,
  input  logic [MAG_W-1:0] din,
  output logic             vout,
  output logic [MAG_W-1:0] level,
  output logic [MAG_W-1:0] hold,
  output logic             hold_active,
  output logic             pwm_out
);

  localparam int CNT_W = $clog2(HOLD_UPDATES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_UPDATES - 1);

  // vin/din is a plain strobe with no backpressure: a new peak may arrive every
  // cycle, and each one produces exactly one vout strobe on the following cycle.
  logic             vout_q, vout_d;
  logic [MAG_W-1:0] level_q, level_d;
  logic [MAG_W-1:0] hold_q, hold_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  hold_state_t      state_q, state_d;

  always_comb begin
    vout_d     = vin;
    level_d    = level_q;
    hold_d     = hold_q;
    hold_cnt_d = hold_cnt_q;
    state_d    = state_q;
    if (vin) begin
      if (din >= level_q) level_d = din;
      else                level_d = decay(level_q, din, DECAY_SHIFT);

      if (din >= hold_q) begin
        hold_d     = din;
        hold_cnt_d = '0;
        state_d    = HOLD;
      end else if (state_q == HOLD) begin
        if (hold_cnt_q == CNT_LAST) state_d = FALL;
        else                        hold_cnt_d = hold_cnt_q + CNT_W'(1);
      end else begin
        // Falling marker is floored at the new level so hold never drops below it.
        hold_d = decay(hold_q, level_d, DECAY_SHIFT);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vout_q     <= 1'b0;
      level_q    <= '0;
      hold_q     <= '0;
      hold_cnt_q <= '0;
      state_q    <= FALL;
    end else begin
      vout_q     <= vout_d;
      level_q    <= level_d;
      hold_q     <= hold_d;
      hold_cnt_q <= hold_cnt_d;
      state_q    <= state_d;
    end
  end

  assign vout        = vout_q;
  assign level       = level_q;
  assign hold        = hold_q;
  assign hold_active = (state_q == HOLD);

  meter_pwm #(
    .PWM_BITS(PWM_BITS)
  ) u_pwm (
    .clk     (clk),
    .rst     (rst),
    .duty_in (level_q[MAG_W-1 -: PWM_BITS]),
    .pwm_out (pwm_out)
  );

endmodule
